// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage elastic buffers of the 5-stage core:
// bubble word, halt flag width, per-boundary payload layouts and sizing helpers.
package pipe_pkg;

    localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
    localparam int          HALT_BIT_W = 1;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_ACTIVE = 1'b1
    } buf_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] imm_ext;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [11:0] ctrl;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] alu_out;
        logic [31:0] store_val;
        logic [4:0]  dest;
        logic [5:0]  ctrl;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  dest;
        logic        reg_write;
    } mem_wb_t;

    // Pointer width, never below one bit so a single-entry buffer still has a pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_buf_ctrl.sv
// Control half of the elastic buffer: pointers, occupancy, sticky halt and
// the ready/valid equations. Holds no payload.
module pipe_buf_ctrl
    import pipe_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = ptr_width(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             in_valid,
    input  logic             in_halted,
    input  logic             out_ready,
    input  logic             lock,
    input  logic             flush,
    output logic             in_ready,
    output logic             out_valid,
    output logic             wr_en,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halt_q, halt_d;
    logic             push, pop;
    buf_state_t       state;

    // Explicit wrap keeps DEPTH=1 correct, where the 1-bit pointer must stay at 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            halt_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            halt_q <= halt_d;
        end
    end

    always_comb begin
        state     = (cnt_q == '0) ? ST_EMPTY : ST_ACTIVE;
        out_valid = (state == ST_ACTIVE);
        in_ready  = !lock && !halt_q && (cnt_q < CNT_W'(DEPTH));
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready && !lock && !flush;
        wr_en     = push && !flush;

        rd_d   = rd_q;
        wr_d   = wr_q;
        cnt_d  = cnt_q;
        halt_d = halt_q;

        // Flush squashes everything, including a push offered in the same cycle.
        if (flush) begin
            rd_d   = '0;
            wr_d   = '0;
            cnt_d  = '0;
            halt_d = 1'b0;
        end else begin
            if (push) begin
                wr_d   = ptr_inc(wr_q);
                halt_d = halt_q | in_halted;
            end
            if (pop) begin
                rd_d = ptr_inc(rd_q);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    assign wr_ptr = wr_q;
    assign rd_ptr = rd_q;
    assign count  = cnt_q;

endmodule

// File: rtl/elastic_pipe_buffer.sv
// DEPTH-entry elastic FIFO used between pipeline stages; stores payload plus a
// halted flag and presents NOP_VALUE as a bubble whenever it is empty.
module elastic_pipe_buffer
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_WORD)
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_halted,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_halted,
    input  logic                       lock,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = ptr_width(DEPTH);

    if (DEPTH < 1 || DEPTH > 8 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("elastic_pipe_buffer: DEPTH must be a power of two in 1..8");
    end

    logic [DATA_W-1:0]     data_mem [DEPTH];
    logic [HALT_BIT_W-1:0] halt_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic                  wr_en;

    pipe_buf_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .in_halted (in_halted),
        .out_ready (out_ready),
        .lock      (lock),
        .flush     (flush),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .wr_en     (wr_en),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .count     (count)
    );

    // Storage is not reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr] <= in_data;
            halt_mem[wr_ptr] <= HALT_BIT_W'(in_halted);
        end
    end

    assign out_data   = out_valid ? data_mem[rd_ptr] : NOP_VALUE;
    assign out_halted = out_valid & halt_mem[rd_ptr][0];

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
// Scoreboard bench for elastic_pipe_buffer: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_elastic_pipe_buffer;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        in_valid, in_ready, in_halted;
    logic [31:0] in_data;
    logic        out_valid, out_ready, out_halted;
    logic [31:0] out_data;
    logic        lock, flush;
    logic [1:0]  count;

    elastic_pipe_buffer #(
        .DATA_W    (32),
        .DEPTH     (DEPTH),
        .NOP_VALUE (32'h0)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_halted  (in_halted),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_halted (out_halted),
        .lock       (lock),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        halted;
    } ent_t;

    ent_t sb[$];
    int   m_cnt  = 0;
    bit   m_halt = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy and sticky halt from the handshake rules.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_cnt  = 0;
            m_halt = 1'b0;
            sb.delete();
        end else if (flush) begin
            m_cnt  = 0;
            m_halt = 1'b0;
            sb.delete();
        end else begin
            automatic bit acc = in_valid && !lock && !m_halt && (m_cnt < DEPTH);
            automatic bit rel = (m_cnt > 0) && out_ready && !lock;
            if (acc) begin
                sb.push_back('{data: in_data, halted: in_halted});
                if (in_halted) m_halt = 1'b1;
            end
            m_cnt = m_cnt + int'(acc) - int'(rel);
        end
    end

    // Monitor: compares the presented head with the scoreboard, consumes on pop.
    always @(negedge clk) begin
        if (rst_b === 1'b1) begin
            check("count", 64'(count), 64'(m_cnt));
            check("in_ready", 64'(in_ready), 64'(!lock && !m_halt && (m_cnt < DEPTH)));
            check("out_valid", 64'(out_valid), 64'(m_cnt > 0));
            if (sb.size() > 0) begin
                check("out_data", 64'(out_data), 64'(sb[0].data));
                check("out_halted", 64'(out_halted), 64'(sb[0].halted));
                if (out_ready && !lock && !flush) void'(sb.pop_front());
            end else begin
                check("bubble_data", 64'(out_data), 64'h0);
                check("bubble_halted", 64'(out_halted), 64'h0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] d, input logic h);
        in_valid  = 1'b1;
        in_data   = d;
        in_halted = h;
        tick();
        in_valid  = 1'b0;
        in_halted = 1'b0;
    endtask

    initial begin
        rst_b = 1'b0; in_valid = 1'b0; in_data = '0; in_halted = 1'b0;
        out_ready = 1'b0; lock = 1'b0; flush = 1'b0;
        #12;
        check("rst_count", 64'(count), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h1);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_halted", 64'(out_halted), 64'h0);
        rst_b = 1'b1;

        // basic flow
        push(32'h2008_0005, 1'b0);
        check("basic_valid", 64'(out_valid), 64'h1);
        check("basic_data", 64'(out_data), 64'h2008_0005);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("basic_pop_valid", 64'(out_valid), 64'h0);
        check("basic_pop_data", 64'(out_data), 64'h0);

        // fill and drain
        push(32'hAAAA_0001, 1'b0);
        push(32'hBBBB_0002, 1'b0);
        check("fill_count", 64'(count), 64'h2);
        check("fill_in_ready", 64'(in_ready), 64'h0);
        out_ready = 1'b1;
        check("drain_a", 64'(out_data), 64'hAAAA_0001);
        tick();
        check("drain_b", 64'(out_data), 64'hBBBB_0002);
        tick();
        out_ready = 1'b0;
        check("drain_count", 64'(count), 64'h0);

        // lock
        push(32'hCCCC_0003, 1'b0);
        in_valid = 1'b1; in_data = 32'hEEEE_0004; out_ready = 1'b1; lock = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lock_count", 64'(count), 64'h1);
            check("lock_head", 64'(out_data), 64'hCCCC_0003);
            check("lock_in_ready", 64'(in_ready), 64'h0);
        end
        lock = 1'b0; in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        check("lock_release_count", 64'(count), 64'h0);

        // flush beats lock and push
        push(32'h1111_0005, 1'b0);
        push(32'h2222_0006, 1'b0);
        flush = 1'b1; lock = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_0007;
        tick();
        flush = 1'b0; lock = 1'b0; in_valid = 1'b0;
        check("flush_count", 64'(count), 64'h0);
        check("flush_valid", 64'(out_valid), 64'h0);
        check("flush_data", 64'(out_data), 64'h0);
        tick();
        check("flush_not_stored", 64'(count), 64'h0);

        // halt
        push(32'hDDDD_0008, 1'b1);
        check("halt_in_ready", 64'(in_ready), 64'h0);
        check("halt_out_halted", 64'(out_halted), 64'h1);
        in_valid = 1'b1; in_data = 32'h3333_0009; out_ready = 1'b1;
        tick();
        check("halt_drained", 64'(count), 64'h0);
        tick();
        check("halt_refused", 64'(count), 64'h0);
        check("halt_still_blocked", 64'(in_ready), 64'h0);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("halt_cleared", 64'(in_ready), 64'h1);

        // asynchronous reset mid-operation
        push(32'h4444_000A, 1'b0);
        push(32'h5555_000B, 1'b0);
        #1 rst_b = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'h0);
        check("arst_valid", 64'(out_valid), 64'h0);
        check("arst_in_ready", 64'(in_ready), 64'h1);
        rst_b = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(99) < 70);
            in_data   = $urandom;
            in_halted = ($urandom_range(99) < 3);
            out_ready = ($urandom_range(99) < 60);
            lock      = ($urandom_range(99) < 10);
            flush     = ($urandom_range(99) < 4);
            tick();
        end
        in_valid = 1'b0; in_halted = 1'b0; lock = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elastic_pipe_buffer.md
Name: elastic_pipe_buffer

Overview:
- Parametrised successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB stage registers of the 5-stage MIPS core.
- One instance replaces any inter-stage buffer. It is a DEPTH-entry elastic FIFO carrying an opaque payload plus a per-entry halted flag.
- Adds features the fixed buffers lack: valid/ready handshake, global lock (cache-miss stall), flush (branch squash with bubble insertion) and sticky halt blocking.
- Sits between two pipeline stages. It is not a full stage, and holds no datapath logic beyond storage and control.

Parameters:
- DATA_W, 32, payload width in bits (instruction, PC, control bundle, concatenated by the instantiator).
- DEPTH, 2, number of entries; power of two, 1..8.
- NOP_VALUE, '0, payload presented on out_data when empty (bubble, e.g. 32'h0000_0000 = sll $0,$0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  buffer accepts an entry this cycle.
- in_data  in  DATA_W  upstream payload.
- in_halted  in  1  upstream halted flag (syscall-halt seen).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head this cycle.
- out_data  out  DATA_W  head payload, or NOP_VALUE when empty.
- out_halted  out  1  head halted flag, 0 when empty.
- lock  in  1  global stall; freezes buffer.
- flush  in  1  squash all entries.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (async, rst_b=0):
  - Pointers and count go to 0; halt_seen=0.
  - Outputs: out_valid=0, out_data=NOP_VALUE, out_halted=0, count=0, in_ready=1.
  - Reset mid-operation discards all contents immediately, without waiting for clk.
- Storage:
  - Circular array; rd_ptr and wr_ptr are $clog2(DEPTH) bits (1 bit minimum) and wrap modulo DEPTH.
  - count is tracked separately, so full and empty are unambiguous.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready & !lock & !flush.
  - in_ready = !lock & !halt_seen & (count < DEPTH). It does not depend on out_ready, so there is no ready combinational path.
- Latency:
  - An entry pushed at edge N is visible on out_* after edge N (1 cycle).
  - There is no combinational in-to-out bypass, even when empty.
- Simultaneous push and pop with count<DEPTH: both happen and count is unchanged. When full, no push is possible that cycle; the pop frees a slot for the next cycle.
- lock=1: no push, no pop, all state held. out_* hold their values, and out_valid stays high if it was high.
- flush=1 (priority over lock and over a same-cycle push):
  - Next edge: count=0, rd_ptr=wr_ptr=0, halt_seen=0.
  - The input presented that cycle is discarded.
  - From the next cycle: out_valid=0 and out_data=NOP_VALUE.
- Halt:
  - A push with in_halted=1 sets halt_seen at that edge.
  - in_ready then stays 0 until flush or reset; entries already stored still drain.
  - out_halted = out_valid & head.halted.
- Empty: out_data=NOP_VALUE, out_halted=0, and out_ready is ignored.
- Full: in_ready=0; in_valid without acceptance is not an error, and upstream must hold its data.
- Control is a two-state machine (EMPTY and ACTIVE, derived from count) plus the halt_seen flag. No other hidden state.

Decomposition:
- Shared package pipe_pkg: NOP_WORD constant (32'h0), HALT_BIT_W=1, and a payload struct typedef per stage boundary (if_id_t, id_ex_t, ex_mem_t, mem_wb_t).
- Instantiators pass $bits(stage_t) as DATA_W.
- One natural sub-module, pipe_buf_ctrl: pointers, count, halt_seen and the ready/valid equations.
- The storage array stays in elastic_pipe_buffer.

Test Plan:
- Reset and basic flow, DEPTH=2: after rst_b release, push 32'h2008_0005 → out_valid=1 with out_data=32'h2008_0005 one edge later; pop → out_valid=0 and out_data=32'h0.
- Fill and drain: hold out_ready=0 and push A, B → count=2, in_ready=0. Assert out_ready for 2 cycles → A then B in order, and count reaches 0.
- Lock: count=1 with head C, set lock=1 for 3 cycles with in_valid=1 and out_ready=1 → count stays 1, head stays C, in_ready=0. Release → C pops the next edge.
- Flush priority: count=2, assert flush, lock and in_valid together → next cycle count=0, out_valid=0, out_data=0, and the input is not stored.
- Halt: push D with in_halted=1 → in_ready=0 afterwards while D drains with out_halted=1. Further pushes are refused until flush, after which in_ready=1.
- Async reset mid-operation: count=2, drop rst_b between edges → count=0 and out_valid=0 immediately, with no clock edge required.
